// File: rtl/lives_pkg.sv
// Shared definitions for the lives bar: transparency key, FSM states and
// the lives-count width helper.
package lives_pkg;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    GRACE = 2'd1,
    DEAD  = 2'd2
  } lives_state_t;

  function automatic int unsigned lives_width(input int unsigned max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/heart_tile_rom.sv
// Combinational heart tile ROM. The 8x8 heart shape is scaled up to a
// 2^TILE_BITS square by using the top three bits of row/col (TILE_BITS >= 3).
module heart_tile_rom
  import lives_pkg::*;
#(
  parameter int unsigned TILE_BITS = 5
) (
  input  logic [TILE_BITS-1:0] row,
  input  logic [TILE_BITS-1:0] col,
  output logic [7:0]           colour
);

  // One byte per shape row, column 0 is the MSB.
  localparam logic [7:0] SHAPE [8] = '{8'h66, 8'hFF, 8'hFF, 8'hFF,
                                       8'h7E, 8'h3C, 8'h18, 8'h00};
  localparam logic [7:0] BODY = 8'hE0;

  logic [2:0] r;
  logic [2:0] c;
  logic [7:0] shape_row;

  // Texel lookup: scaled shape bit selects body colour or transparency.
  always_comb begin
    r         = row[TILE_BITS-1 -: 3];
    c         = col[TILE_BITS-1 -: 3];
    shape_row = SHAPE[r];
    colour    = shape_row[3'd7 - c] ? BODY : TRANSPARENT_ENCODING;
  end

endmodule

// File: rtl/lives_bar_bitmap.sv
// Lives indicator bar for the HUD: draws heart tiles, tracks lives with
// extra-life gain, post-hit grace window and a one-cycle game-over pulse.
// Optional feature macro: LIVES_BLINK_EN (lost heart blinks during grace).
module lives_bar_bitmap
  import lives_pkg::*;
#(
  parameter int unsigned MAX_LIVES    = 5,
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned TILE_BITS    = 5,
  parameter int unsigned GRACE_FRAMES = 90,
  parameter int unsigned BLINK_SHIFT  = 3
) (
  input  logic                                 clk,
  input  logic                                 resetN,
  input  logic [10:0]                          offsetX,
  input  logic [10:0]                          offsetY,
  input  logic                                 InsideRectangle,
  input  logic                                 startOfFrame,
  input  logic                                 strike,
  input  logic                                 extraLife,
  output logic                                 drawingRequest,
  output logic [7:0]                           RGBout,
  output logic [lives_width(MAX_LIVES)-1:0]    livesLeft,
  output logic                                 invulnerable,
  output logic                                 gameOver
);

  localparam int unsigned LW = lives_width(MAX_LIVES);
  localparam int unsigned GW = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES) : 1;

  lives_state_t  state_q, state_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [LW-1:0] lost_q, lost_d;
  logic [GW-1:0] grace_q, grace_d;
  logic          over_q, over_d;
  logic          done_q, done_d;
  logic [7:0]    rgb_q, rgb_d;
  logic          blink_on;

  logic [LW-1:0] lives_inc;
  logic [10:0]   slot;
  logic [7:0]    texel;
  logic          show_slot;

  assign lives_inc = (lives_q == LW'(MAX_LIVES)) ? lives_q : lives_q + LW'(1);

`ifdef LIVES_BLINK_EN
  logic [BLINK_SHIFT:0] frame_q;

  // Free-running frame counter; its top bit is the blink phase.
  always_ff @(posedge clk) begin
    if (!resetN) frame_q <= '0;
    else if (startOfFrame) frame_q <= frame_q + 1'b1;
  end

  assign blink_on = frame_q[BLINK_SHIFT];
`else
  assign blink_on = 1'b0;
`endif

  // Lives FSM next-state. The game-over pulse is raised on the first cycle
  // spent in DEAD; done_q blocks any repeat until reset.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    lost_d  = lost_q;
    grace_d = grace_q;
    over_d  = 1'b0;
    done_d  = done_q;
    unique case (state_q)
      ALIVE: begin
        if (strike && extraLife) begin
          state_d = GRACE;
          grace_d = GW'(GRACE_FRAMES - 1);
          lost_d  = lives_q;
        end else if (strike) begin
          lives_d = lives_q - LW'(1);
          if (lives_q == LW'(1)) begin
            state_d = DEAD;
          end else begin
            state_d = GRACE;
            grace_d = GW'(GRACE_FRAMES - 1);
            lost_d  = lives_q - LW'(1);
          end
        end else if (extraLife) begin
          lives_d = lives_inc;
        end
      end
      GRACE: begin
        if (extraLife) lives_d = lives_inc;
        if (startOfFrame) begin
          if (grace_q == '0) state_d = ALIVE;
          else grace_d = grace_q - GW'(1);
        end
      end
      DEAD: begin
        over_d = !done_q;
        done_d = 1'b1;
      end
      default: state_d = ALIVE;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= ALIVE;
      lives_q <= LW'(INIT_LIVES);
      lost_q  <= '0;
      grace_q <= '0;
      over_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      lost_q  <= lost_d;
      grace_q <= grace_d;
      over_q  <= over_d;
      done_q  <= done_d;
    end
  end

  heart_tile_rom #(
    .TILE_BITS (TILE_BITS)
  ) u_rom (
    .row    (offsetY[TILE_BITS-1:0]),
    .col    (offsetX[TILE_BITS-1:0]),
    .colour (texel)
  );

  // Pixel path: choose texel or transparency for the registered output.
  always_comb begin
    slot      = offsetX >> TILE_BITS;
    show_slot = (slot < 11'(lives_q)) ||
                (blink_on && (state_q == GRACE) && (slot == 11'(lost_q)));
    rgb_d     = TRANSPARENT_ENCODING;
    if (InsideRectangle && ((offsetY >> TILE_BITS) == '0) &&
        (slot < 11'(MAX_LIVES)) && show_slot)
      rgb_d = texel;
  end

  // Registered pixel colour.
  always_ff @(posedge clk) begin
    if (!resetN) rgb_q <= TRANSPARENT_ENCODING;
    else rgb_q <= rgb_d;
  end

  assign RGBout         = rgb_q;
  assign drawingRequest = (rgb_q != TRANSPARENT_ENCODING);
  assign livesLeft      = lives_q;
  assign invulnerable   = (state_q == GRACE);
  assign gameOver       = over_q;

endmodule
